// File: rtl/opti_in_pacer.sv
// opti_in_pacer: input sample pacer in front of the 4-stage SOS cascade.
// Samples are accepted over a valid/ready handshake and buffered in a small FIFO.
// They are released as one-cycle strobes spaced at least GAP cycles apart.
// Optional feature macro: OPTI_PACER_STATS_EN. It builds the saturating
// issued-sample counter; without it, sample_cnt is tied to zero.
module opti_in_pacer #(
   parameter int DW    = 24,
   parameter int DEPTH = 8,
   parameter int AW    = 3,
   parameter int GAP   = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic signed [DW-1:0] s_data,
   input  logic                 s_valid,
   output logic                 s_ready,
   input  logic                 flush,
   output logic signed [DW-1:0] data_out,
   output logic                 data_valid_out,
   output logic [AW:0]          level,
   output logic                 bp_seen,
   output logic [15:0]          sample_cnt
);

   localparam int LW = AW + 1;
   localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic [GW-1:0] gap_cnt_q, gap_cnt_d;
   logic [DW-1:0] data_out_q, data_out_d;
   logic          dv_q, dv_d;
   logic          bp_q, bp_d;
   logic          wr_en_s;
   logic          issue_s;

   // Full is decided from the occupancy count alone; no write-through when full.
   assign s_ready        = (level_q != LW'(DEPTH));
   assign data_out       = data_out_q;
   assign data_valid_out = dv_q;
   assign level          = level_q;
   assign bp_seen        = bp_q;

   // Handshake and issue qualification; flush blocks both.
   always_comb begin
      wr_en_s = s_valid && s_ready && !flush;
      issue_s = (level_q != {LW{1'b0}}) && (gap_cnt_q == {GW{1'b0}}) && !flush;
   end

   // Next-state logic for pointers, occupancy, pacing timer, output stage and flag.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      gap_cnt_d  = gap_cnt_q;
      data_out_d = data_out_q;
      dv_d       = 1'b0;
      bp_d       = bp_q;
      if (flush) begin
         wr_ptr_d  = {AW{1'b0}};
         rd_ptr_d  = {AW{1'b0}};
         level_d   = {LW{1'b0}};
         gap_cnt_d = {GW{1'b0}};
         bp_d      = 1'b0;
      end else begin
         if (wr_en_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (issue_s) begin
            rd_ptr_d   = rd_ptr_q + AW'(1);
            data_out_d = mem_q[rd_ptr_q];
            dv_d       = 1'b1;
            gap_cnt_d  = GW'(GAP - 1);
         end else if (gap_cnt_q != {GW{1'b0}}) begin
            gap_cnt_d = gap_cnt_q - GW'(1);
         end else begin
            gap_cnt_d = gap_cnt_q;
         end
         case ({wr_en_s, issue_s})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
         endcase
         if (s_valid && !s_ready) begin
            bp_d = 1'b1;
         end else begin
            bp_d = bp_q;
         end
      end
   end

   // Control and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= {AW{1'b0}};
         rd_ptr_q   <= {AW{1'b0}};
         level_q    <= {LW{1'b0}};
         gap_cnt_q  <= {GW{1'b0}};
         data_out_q <= {DW{1'b0}};
         dv_q       <= 1'b0;
         bp_q       <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         gap_cnt_q  <= gap_cnt_d;
         data_out_q <= data_out_d;
         dv_q       <= dv_d;
         bp_q       <= bp_d;
      end
   end

   // Sample storage; contents are only read behind the level count, so no reset.
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         mem_q[wr_ptr_q] <= s_data;
      end
   end

`ifdef OPTI_PACER_STATS_EN
   logic [15:0] cnt_q, cnt_d;

   // Saturating count of issued strobes, cleared by flush.
   always_comb begin
      cnt_d = cnt_q;
      if (flush) begin
         cnt_d = 16'h0000;
      end else if (issue_s && (cnt_q != 16'hFFFF)) begin
         cnt_d = cnt_q + 16'h0001;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Issued-sample counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= 16'h0000;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign sample_cnt = cnt_q;
`else
   assign sample_cnt = 16'h0000;
`endif

endmodule
